// File: rtl/bnn_pkg.sv
// Shared constants and types for the binarized activation packing path.
package bnn_pkg;

    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 11;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(WORD_W);

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with a registered occupancy count; storage is not reset.
module sync_word_fifo
    import bnn_pkg::*;
#(
    parameter int W     = WORD_W + 1,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop    = pop & (count != '0);
    assign do_push   = push & (count != CW'(DEPTH));
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/act_pack_buffer.sv
// Packs sign-activation bits LSB-first into words and streams them through a FIFO.
// Optional per-layer ones count enabled with `define ACT_POPCNT_EN.
module act_pack_buffer
    import bnn_pkg::*;
#(
    parameter int WORD_W     = bnn_pkg::WORD_W,
    parameter int FIFO_DEPTH = bnn_pkg::FIFO_DEPTH,
    parameter int CNT_W      = bnn_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act_valid,
    input  logic              act_bit,
    input  logic              act_last,
    output logic              act_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              drop_err,
    output logic [CNT_W-1:0]  layer_cnt
`ifdef ACT_POPCNT_EN
    ,
    output logic [CNT_W-1:0]  ones_cnt,
    output logic              ones_vld
`endif
);

    localparam int IX_W = $clog2(WORD_W);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WORD_W-1:0] pack_reg;
    logic [IX_W-1:0]   idx;
    logic [WORD_W-1:0] word_p0;
    logic              accept;
    logic              push;
    logic              pop;
    logic [CW-1:0]     fifo_count;
    entry_t            push_entry;
    entry_t            head_entry;

    assign accept    = act_valid & act_ready;
    assign push      = accept & ((idx == IX_W'(WORD_W - 1)) | act_last);
    assign act_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? head_entry.data : '0;
    assign out_last  = out_valid & head_entry.last;

    always_comb begin
        word_p0      = pack_reg;
        word_p0[idx] = act_bit;
    end

    always_comb begin
        push_entry      = '0;
        push_entry.last = act_last;
        push_entry.data = word_p0;
    end

    // Packing register / bit index -> FIFO entry on the completing accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_reg  <= '0;
            idx       <= '0;
            layer_cnt <= '0;
            drop_err  <= 1'b0;
        end else begin
            if (accept) begin
                if (push) begin
                    pack_reg <= '0;
                    idx      <= '0;
                end else begin
                    pack_reg <= word_p0;
                    idx      <= idx + IX_W'(1);
                end
                layer_cnt <= act_last ? '0 : sat_inc(layer_cnt);
            end
            if (act_valid & ~act_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

    sync_word_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

`ifdef ACT_POPCNT_EN
    logic [CNT_W-1:0] tally;

    // Tally of accepted ones; snapshot on the layer's final accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tally    <= '0;
            ones_cnt <= '0;
            ones_vld <= 1'b0;
        end else begin
            ones_vld <= accept & act_last;
            if (accept) begin
                if (act_last) begin
                    tally    <= '0;
                    ones_cnt <= act_bit ? sat_inc(tally) : tally;
                end else if (act_bit) begin
                    tally <= sat_inc(tally);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_act_pack_buffer.sv
// Directed self-checking bench for act_pack_buffer (immediate assertions).
module tb_act_pack_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        act_valid;
    logic        act_bit;
    logic        act_last;
    logic        act_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        drop_err;
    logic [10:0] layer_cnt;
`ifdef ACT_POPCNT_EN
    logic [10:0] ones_cnt;
    logic        ones_vld;
`endif

    int checks = 0;
    int errors = 0;

    act_pack_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .act_valid (act_valid),
        .act_bit   (act_bit),
        .act_last  (act_last),
        .act_ready (act_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .drop_err  (drop_err),
        .layer_cnt (layer_cnt)
`ifdef ACT_POPCNT_EN
        ,
        .ones_cnt  (ones_cnt),
        .ones_vld  (ones_vld)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic l);
        act_valid = 1'b1;
        act_bit   = b;
        act_last  = l;
        cyc();
        act_valid = 1'b0;
        act_bit   = 1'b0;
        act_last  = 1'b0;
    endtask

    function automatic logic tp_bit(input int i);
        return logic'(((i * 13) >> 2) ^ (i >> 5) ^ i);
    endfunction

    initial begin
        logic [7:0] bits8;
        logic [7:0] bp_words [5];
        logic [7:0] exp_w;
        logic [7:0] drain_w [4];
        int stalls;
        int lasts;
        int bad_words;

        bp_words = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81};
        drain_w  = '{8'hFF, 8'hFF, 8'hFF, 8'h02};
        rst = 1'b1; act_valid = 1'b0; act_bit = 1'b0; act_last = 1'b0; out_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_act_ready", 32'(act_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_drop_err",  32'(drop_err),  32'd0);
        chk("rst_layer_cnt", 32'(layer_cnt), 32'd0);
        rst = 1'b0;
        cyc();

        // Bit ordering: 1,0,1,1,0,0,0,1 -> 0x8D
        out_ready = 1'b1;
        bits8 = 8'b1000_1101;
        for (int i = 0; i < 7; i++) send(bits8[i], 1'b0);
        chk("ord_layer_cnt7", 32'(layer_cnt), 32'd7);
        chk("ord_no_early_valid", 32'(out_valid), 32'd0);
        send(bits8[7], 1'b1);
        chk("ord_valid", 32'(out_valid), 32'd1);
        chk("ord_data",  32'(out_data),  32'h8D);
        chk("ord_last",  32'(out_last),  32'd1);
        chk("ord_layer_cnt0", 32'(layer_cnt), 32'd0);
        cyc();
        chk("ord_popped", 32'(out_valid), 32'd0);

        // Partial word: 1,1,0 with last -> 0x03
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        chk("part_data", 32'(out_data), 32'h03);
        chk("part_last", 32'(out_last), 32'd1);
        cyc();

        // Backpressure: 32 bits fill the FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_w = bp_words[i / 8];
            send(exp_w[i % 8], 1'b0);
            if (i == 30) chk("bp_ready_before_4th", 32'(act_ready), 32'd1);
        end
        chk("bp_ready_low", 32'(act_ready), 32'd0);
        chk("bp_drop_clear", 32'(drop_err), 32'd0);
        cyc(); cyc();
        chk("bp_head_held", 32'(out_data), 32'hA5);
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_ready_still_low", 32'(act_ready), 32'd0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("bp_ready_after_pop", 32'(act_ready), 32'd1);
        chk("bp_head2", 32'(out_data), 32'h3C);
        for (int i = 32; i < 40; i++) begin
            exp_w = bp_words[i / 8];
            send(exp_w[i % 8], 1'b0);
        end
        chk("bp_layer_cnt40", 32'(layer_cnt), 32'd40);
        chk("bp_full_again", 32'(act_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("bp_drain%0d", k), 32'(out_data), 32'(bp_words[k]));
            chk($sformatf("bp_drain_last%0d", k), 32'(out_last), 32'd0);
            cyc();
        end
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_no_drop", 32'(drop_err), 32'd0);

        // Drop while full
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(1'b1, 1'b0);
        chk("drop_full", 32'(act_ready), 32'd0);
        act_valid = 1'b1; act_bit = 1'b1; act_last = 1'b1;
        cyc(); cyc();
        act_valid = 1'b0; act_bit = 1'b0; act_last = 1'b0;
        chk("drop_err_set", 32'(drop_err), 32'd1);
        chk("drop_layer_cnt", 32'(layer_cnt), 32'd72);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        chk("drop_layer_cnt_clr", 32'(layer_cnt), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drop_drain%0d", k), 32'(out_data), 32'(drain_w[k]));
            chk($sformatf("drop_drain_last%0d", k), 32'(out_last), 32'(k == 3));
            cyc();
        end
        chk("drop_sticky", 32'(drop_err), 32'd1);

        // Async reset mid-layer with a word buffered
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0);
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_drop_err",  32'(drop_err),  32'd0);
        chk("arst_layer_cnt", 32'(layer_cnt), 32'd0);
        chk("arst_act_ready", 32'(act_ready), 32'd1);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        bits8 = 8'h90;
        for (int i = 0; i < 8; i++) send(bits8[i], i == 7);
        chk("fresh_data", 32'(out_data), 32'h90);
        chk("fresh_last", 32'(out_last), 32'd1);
        cyc();

        // Throughput: 1024 activations, 128 words
        stalls = 0; lasts = 0; bad_words = 0; exp_w = '0;
        for (int i = 0; i < 1024; i++) begin
            if (!act_ready) stalls++;
            exp_w[i % 8] = tp_bit(i);
            send(tp_bit(i), i == 1023);
            if (i == 1022) chk("tp_layer_cnt1023", 32'(layer_cnt), 32'd1023);
            if (i % 8 == 7) begin
                if (!(out_valid && out_data == exp_w)) bad_words++;
                if (out_last) lasts++;
                if (i == 1023) chk("tp_final_last", 32'(out_last), 32'd1);
            end else if (out_valid) begin
                bad_words++;
            end
        end
        chk("tp_word_errs", 32'(bad_words), 32'd0);
        chk("tp_last_count", 32'(lasts), 32'd1);
        chk("tp_stalls", 32'(stalls), 32'd0);
        chk("tp_layer_cnt0", 32'(layer_cnt), 32'd0);
        cyc();
        chk("tp_empty", 32'(out_valid), 32'd0);

`ifdef ACT_POPCNT_EN
        // 20-bit layer with ones at 0,3,5,8,13,17,19
        for (int i = 0; i < 20; i++) begin
            send(i == 0 || i == 3 || i == 5 || i == 8 || i == 13 || i == 17 || i == 19, i == 19);
            if (i == 18) chk("pc_no_early_vld", 32'(ones_vld), 32'd0);
        end
        chk("pc_vld", 32'(ones_vld), 32'd1);
        chk("pc_cnt7", 32'(ones_cnt), 32'd7);
        cyc();
        chk("pc_vld_pulse", 32'(ones_vld), 32'd0);
        chk("pc_cnt_hold", 32'(ones_cnt), 32'd7);
        for (int i = 0; i < 8; i++) send(1'b0, i == 7);
        chk("pc_vld2", 32'(ones_vld), 32'd1);
        chk("pc_cnt0", 32'(ones_cnt), 32'd0);
        cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_pack_buffer.md
Name: act_pack_buffer

Overview:
- Downstream of the binarized compute stage: consumes one sign-activation bit per accepted strobe and packs the bits LSB-first into WORD_W-bit words.
- Words are buffered in a small FIFO and streamed out over a valid/ready interface, with a last flag on each layer's final word.
- Backpressures the compute stage when the FIFO is full; sticky error flags bits that were dropped.

Parameters:
- WORD_W, 8, packed output word width; power of two, at least 2.
- FIFO_DEPTH, 4, number of word entries; power of two.
- CNT_W, 11, width of the per-layer activation counter; covers 1024 neurons.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- act_valid  in  1  activation strobe from compute stage.
- act_bit  in  1  activation value; 1 = non-negative sum.
- act_last  in  1  qualifies act_valid; final activation of the layer.
- act_ready  out  1  block can accept an activation this cycle.
- out_valid  out  1  FIFO head word is valid.
- out_data  out  WORD_W  FIFO head word; bit k = k-th activation of that word.
- out_last  out  1  head word is the final word of its layer.
- out_ready  in  1  consumer accepts the head word.
- drop_err  out  1  sticky; an activation arrived while act_ready was 0.
- layer_cnt  out  CNT_W  activations accepted in the current layer.

Behaviour:
- Reset (async, any time including mid-layer): FIFO empty; packing register, bit index and layer_cnt = 0; out_valid = 0; out_data = 0; out_last = 0; act_ready = 1; drop_err = 0.
- Accept = act_valid & act_ready. On accept:
  - act_bit is written at bit index idx of the packing register.
  - idx increments; layer_cnt increments and saturates at all-ones.
- Word push, on the same edge as the accept:
  - Trigger: the accept fills bit WORD_W-1, or act_last = 1.
  - The completed word, with the new bit merged, is written to the FIFO with last = act_last.
  - Unfilled upper bits are 0 (zero padding on a partial word).
  - idx and the packing register clear.
  - If act_last = 1, layer_cnt clears to 0.
- Latency: the word is visible at out_valid the cycle after the accept that completes it.
- act_ready = (fifo_count < FIFO_DEPTH).
  - Derived from registered count only; no combinational path from out_ready.
  - One free slot is always enough, because at most one push occurs per cycle.
- Pop = out_valid & out_ready.
  - out_valid = (fifo_count != 0).
  - out_data and out_last present the head entry; they are held stable while out_valid & ~out_ready.
- Simultaneous push and pop: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Full FIFO, act_valid = 1:
  - act_ready is 0, so the bit is not accepted; packing state is unchanged.
  - drop_err sets and stays set until reset.
  - A well-behaved compute stage holds act_valid until act_ready.
- Full FIFO with a pop on the same edge: act_ready rises the next cycle. It never rises in the same cycle.
- act_last on the first bit of a word produces a 1-bit word, e.g. 0x01 or 0x00.
- act_last without act_valid is ignored.

Optional Feature:
- Macro: ACT_POPCNT_EN.
- When defined, adds two outputs:
  - ones_cnt  out  CNT_W  number of 1 activations in the most recently completed layer.
  - ones_vld  out  1  one-cycle pulse the cycle after the act_last accept.
  - An internal running tally counts accepted act_bit = 1 and clears on the act_last accept.
  - ones_cnt is latched from tally + act_bit on the act_last accept; it resets to 0.
- When undefined: both ports and the tally logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (bnn_pkg) holds:
  - WORD_W, FIFO_DEPTH and CNT_W default constants.
  - The derived pointer width, log2(FIFO_DEPTH), and the index width, log2(WORD_W).
  - Typedef of the FIFO entry struct {last, data[WORD_W]}.
- One natural sub-module, sync_word_fifo: parameterised storage, pointers and count, with a registered count output. The packer and flag logic remain in act_pack_buffer.

Test Plan:
- Bit ordering: out_ready = 1; send 8 accepts with bits 1,0,1,1,0,0,0,1 and act_last on the 8th -> one word 0x8D with out_last = 1, appearing 1 cycle after the 8th accept; layer_cnt returns to 0.
- Partial word: send 3 accepts with bits 1,1,0, last on the 3rd -> word 0x03 with out_last = 1; the upper bits are zero.
- Backpressure: out_ready = 0; stream 40 bits continuously while obeying act_ready -> act_ready falls after the 4th word is pushed and drop_err stays 0. Then raise out_ready -> words drain in order, and act_ready returns 1 the cycle after the first pop.
- Drop: FIFO full; assert act_valid ignoring act_ready -> drop_err = 1 and the packing state is unchanged. Apply rst mid-layer -> drop_err = 0, out_valid = 0, and a fresh 8-bit layer packs from bit 0.
- Throughput: hold out_ready = 1 and stream 1024 activations with act_last on the last -> 128 words; only the last word has out_last; no stalls, act_ready stays 1.
- ACT_POPCNT_EN: layer of 20 bits with seven 1s -> ones_vld pulses once with ones_cnt = 7 one cycle after the last accept. A following layer of all 0s gives ones_cnt = 0.
